lsu_mem_stage: RTL and testbench



---
 rtl/lsu_mem_stage_pkg.sv | 29 ++
 rtl/lsu_lane_align.sv | 21 ++
 rtl/lsu_mem_stage.sv | 153 +++++++++++++++
 tb/tb_lsu_mem_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the load/store stage: FSM encoding, access sizes, lane helpers.
// No logic of its own; imported by lsu_mem_stage and lsu_lane_align.
// Helpers are pure combinational functions of (size, byte offset).
package lsu_mem_stage_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] strb;
        case (size)
            SZ_B:    strb = 4'b0001 << off;
            SZ_H:    strb = 4'b0011 << off;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between a 32-bit word bus and naturally addressed B/H/W accesses.
// Latency: purely combinational.
// Backpressure: none; the caller holds the inputs stable while the bus handshakes.
module lsu_lane_align
    import lsu_mem_stage_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out
);

    assign wstrb     = lane_strb(size, off);
    assign wdata_out = wdata_in << {off, 3'b000};
    // Upper bits zero-fill; sign/zero extension by func3 happens in WBU.
    assign rdata_out = rdata_in >> {off, 3'b000};

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage between EXU and WBU: one instruction at a time, at most one bus transaction.
// Latency: 1 cycle for non-memory ops and misaligned faults, >= 3 cycles for loads/stores.
// Backpressure: in_ready only in IDLE; req fields held until req_ready; out_* held until out_ready.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int PASS_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_alu_out,
    input  logic [31:0]       in_wdata,
    input  logic [2:0]        in_func3,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [PASS_W-1:0] in_pass,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [31:0]       req_addr,
    output logic [31:0]       req_wdata,
    output logic [3:0]        req_wstrb,
    input  logic              rsp_valid,
    input  logic [31:0]       rsp_rdata,
    input  logic              rsp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_alu_out,
    output logic [31:0]       out_mem_rdata,
    output logic [2:0]        out_func3,
    output logic              out_mem_read,
    output logic [PASS_W-1:0] out_pass,
    output logic              out_err
);

    logic [1:0]        state_q, state_d;
    logic [31:0]       alu_q, alu_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        func3_q, func3_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [3:0]  lane_wstrb;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    lsu_lane_align u_align (
        .off       (alu_q[1:0]),
        .size      (func3_q[1:0]),
        .wdata_in  (wdata_q),
        .rdata_in  (rsp_rdata),
        .wstrb     (lane_wstrb),
        .wdata_out (lane_wdata),
        .rdata_out (lane_rdata)
    );

    always_comb begin
        state_d     = state_q;
        alu_d       = alu_q;
        wdata_d     = wdata_q;
        func3_d     = func3_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        pass_d      = pass_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    alu_d       = in_alu_out;
                    wdata_d     = in_wdata;
                    func3_d     = in_func3;
                    mem_read_d  = in_mem_read;
                    // A load+store encoding is treated as a plain load.
                    mem_write_d = in_mem_write & ~in_mem_read;
                    pass_d      = in_pass;
                    rdata_d     = 32'd0;
                    err_d       = 1'b0;
                    if (!(in_mem_read || in_mem_write)) begin
                        state_d = ST_DONE;
                    end else if (misaligned(in_func3[1:0], in_alu_out[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rsp_valid) begin
                    rdata_d = mem_read_q ? lane_rdata : 32'd0;
                    err_d   = rsp_err;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_q       <= 32'd0;
            wdata_q     <= 32'd0;
            func3_q     <= 3'd0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            pass_q      <= '0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_q       <= alu_d;
            wdata_q     <= wdata_d;
            func3_q     <= func3_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            pass_q      <= pass_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign req_valid     = (state_q == ST_REQ);
    assign req_we        = mem_write_q;
    assign req_addr      = alu_q;
    assign req_wdata     = lane_wdata;
    assign req_wstrb     = mem_write_q ? lane_wstrb : 4'b0000;
    assign out_valid     = (state_q == ST_DONE);
    assign out_alu_out   = alu_q;
    assign out_mem_rdata = rdata_q;
    assign out_func3     = func3_q;
    assign out_mem_read  = mem_read_q;
    assign out_pass      = pass_q;
    assign out_err       = err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: vector table driven through a bus responder, results checked via scoreboard.
module tb_lsu_mem_stage;

    localparam int PASS_W = 128;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_alu_out;
    logic [31:0]       in_wdata;
    logic [2:0]        in_func3;
    logic              in_mem_read;
    logic              in_mem_write;
    logic [PASS_W-1:0] in_pass;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_alu_out;
    logic [31:0]       out_mem_rdata;
    logic [2:0]        out_func3;
    logic              out_mem_read;
    logic [PASS_W-1:0] out_pass;
    logic              out_err;

    lsu_mem_stage #(.PASS_W(PASS_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_out(in_alu_out), .in_wdata(in_wdata),
        .in_func3(in_func3), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_pass(in_pass),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_out(out_alu_out),
        .out_mem_rdata(out_mem_rdata), .out_func3(out_func3), .out_mem_read(out_mem_read),
        .out_pass(out_pass), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic        rd;
        logic        wr;
        logic [31:0] bus_rdata;
        logic        bus_err;
        int          req_stall;
        int          rsp_wait;
        logic        early_rsp;
        int          out_stall;
        logic        exp_req;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0]       alu;
        logic [31:0]       rdata;
        logic [2:0]        f3;
        logic              mem_read;
        logic [PASS_W-1:0] pass;
        logic              err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                                input logic rd, input logic wr, input logic [31:0] bus_rdata,
                                input logic bus_err, input int req_stall, input int rsp_wait,
                                input logic early_rsp, input int out_stall, input logic exp_req,
                                input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.f3 = f3; v.rd = rd; v.wr = wr;
        v.bus_rdata = bus_rdata; v.bus_err = bus_err; v.req_stall = req_stall;
        v.rsp_wait = rsp_wait; v.early_rsp = early_rsp; v.out_stall = out_stall;
        v.exp_req = exp_req; v.exp_we = wr & ~rd; v.exp_wstrb = exp_wstrb;
        v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk_req(input vec_t v, input string tag);
        chk({tag, "_req_valid"}, req_valid, 1);
        chk({tag, "_req_addr"}, req_addr, v.addr);
        chk({tag, "_req_we"}, req_we, v.exp_we);
        chk({tag, "_req_wstrb"}, req_wstrb, v.exp_wstrb);
        if (v.exp_we) chk({tag, "_req_wdata"}, req_wdata, v.exp_wdata);
    endtask

    task automatic chk_out(input exp_t e, input string tag);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_out_alu_out"}, out_alu_out, e.alu);
        chk({tag, "_out_mem_rdata"}, out_mem_rdata, e.rdata);
        chk({tag, "_out_func3"}, out_func3, e.f3);
        chk({tag, "_out_mem_read"}, out_mem_read, e.mem_read);
        chk({tag, "_out_pass"}, out_pass, e.pass);
        chk({tag, "_out_err"}, out_err, e.err);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t  e;
        exp_t  got;
        int    cyc;
        int    guard;
        int    exp_lat;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, in_ready, 1);
        in_valid     = 1'b1;
        in_alu_out   = v.addr;
        in_wdata     = v.wdata;
        in_func3     = v.f3;
        in_mem_read  = v.rd;
        in_mem_write = v.wr;
        in_pass      = {$urandom, $urandom, $urandom, $urandom};
        e.alu = v.addr; e.rdata = v.exp_rdata; e.f3 = v.f3; e.mem_read = v.rd;
        e.pass = in_pass; e.err = v.exp_err;
        sb.push_back(e);
        exp_lat = v.exp_req ? 3 + v.req_stall + v.rsp_wait : 1;
        @(negedge clk);
        cyc = 1;
        in_valid     = 1'b0;
        in_alu_out   = 32'hDEAD_BEEF;
        in_wdata     = 32'hFFFF_FFFF;
        in_func3     = 3'b111;
        in_mem_read  = 1'b0;
        in_mem_write = 1'b1;
        in_pass      = '0;
        chk({tag, "_in_ready_busy"}, in_ready, 0);
        if (v.exp_req) begin
            chk_req(v, tag);
            for (int s = 0; s < v.req_stall; s++) begin
                @(negedge clk);
                cyc++;
                chk_req(v, {tag, "_stall"});
            end
            req_ready = 1'b1;
            rsp_valid = v.early_rsp;
            rsp_rdata = 32'h5A5A_5A5A;
            rsp_err   = 1'b1;
            @(negedge clk);
            cyc++;
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            rsp_err   = 1'b0;
            chk({tag, "_req_dropped"}, req_valid, 0);
            chk({tag, "_wait_no_out"}, out_valid, 0);
            for (int w = 0; w < v.rsp_wait; w++) begin
                @(negedge clk);
                cyc++;
            end
            rsp_valid = 1'b1;
            rsp_rdata = v.bus_rdata;
            rsp_err   = v.bus_err;
            @(negedge clk);
            cyc++;
            rsp_valid = 1'b0;
            rsp_rdata = 32'h0;
            rsp_err   = 1'b0;
        end else begin
            chk({tag, "_no_req"}, req_valid, 0);
        end
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            cyc++;
            guard++;
        end
        chk({tag, "_out_valid_seen"}, out_valid, 1);
        if (out_valid) begin
            chk({tag, "_latency"}, cyc, exp_lat);
            if (sb.size() == 0) begin
                chk({tag, "_sb_nonempty"}, 0, 1);
            end else begin
                got = sb.pop_front();
                chk_out(got, tag);
                for (int s = 0; s < v.out_stall; s++) begin
                    @(negedge clk);
                    chk_out(got, {tag, "_hold"});
                end
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_out_released"}, out_valid, 0);
        chk({tag, "_back_idle"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //              addr          wdata         f3      rd    wr    bus_rdata     err   rs ww er  os req strb     exp_wdata     exp_rdata     exp_err
        vecs[0]  = mk(32'h0000_1234, 32'h0,        3'b000, 1'b0, 1'b0, 32'h0,        1'b0, 0, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        1'b0);
        vecs[1]  = mk(32'h0000_0003, 32'h0,        3'b010, 1'b0, 1'b0, 32'h0,        1'b0, 0, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        1'b0);
        vecs[2]  = mk(32'h8000_0003, 32'h0,        3'b000, 1'b1, 1'b0, 32'hAABB_CCDD, 1'b0, 0, 2, 0, 0, 1, 4'b0000, 32'h0,        32'h0000_00AA, 1'b0);
        vecs[3]  = mk(32'h8000_0002, 32'h0000_BEEF, 3'b001, 1'b0, 1'b1, 32'h1122_3344, 1'b0, 3, 0, 0, 0, 1, 4'b1100, 32'hBEEF_0000, 32'h0,        1'b0);
        vecs[4]  = mk(32'h8000_0001, 32'h0,        3'b010, 1'b1, 1'b0, 32'h0,        1'b0, 0, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        1'b1);
        vecs[5]  = mk(32'h8000_0000, 32'h0,        3'b010, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b1, 0, 0, 0, 4, 1, 4'b0000, 32'h0,        32'hCAFE_F00D, 1'b1);
        vecs[6]  = mk(32'h8000_0002, 32'h0,        3'b001, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 0, 1, 1, 0, 1, 4'b0000, 32'h0,        32'h0000_1234, 1'b0);
        vecs[7]  = mk(32'h1000_0001, 32'h0000_00A5, 3'b000, 1'b0, 1'b1, 32'h0,        1'b0, 1, 0, 0, 0, 1, 4'b0010, 32'h0000_A500, 32'h0,        1'b0);
        vecs[8]  = mk(32'h1000_0004, 32'h0102_0304, 3'b010, 1'b0, 1'b1, 32'h0,        1'b0, 0, 0, 0, 0, 1, 4'b1111, 32'h0102_0304, 32'h0,        1'b0);
        vecs[9]  = mk(32'h1000_0001, 32'h0,        3'b100, 1'b1, 1'b0, 32'hAABB_CCDD, 1'b0, 0, 0, 0, 0, 1, 4'b0000, 32'h0,        32'h00AA_BBCC, 1'b0);
        vecs[10] = mk(32'h0000_0020, 32'h7777_7777, 3'b010, 1'b1, 1'b1, 32'h600D_D00D, 1'b0, 0, 0, 0, 0, 1, 4'b0000, 32'h0,        32'h600D_D00D, 1'b0);
        vecs[11] = mk(32'h0000_0003, 32'h0000_1111, 3'b001, 1'b0, 1'b1, 32'h0,        1'b0, 0, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        1'b1);
        vecs[12] = mk(32'h0000_0005, 32'h0,        3'b101, 1'b1, 1'b0, 32'h0,        1'b0, 0, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        1'b1);

        rst = 1'b1;
        in_valid = 1'b0; in_alu_out = 32'h0; in_wdata = 32'h0; in_func3 = 3'b0;
        in_mem_read = 1'b0; in_mem_write = 1'b0; in_pass = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'h0; rsp_err = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_alu_out", out_alu_out, 0);
        chk("rst_out_mem_rdata", out_mem_rdata, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_pass", out_pass, 0);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Reset while waiting for a load response, then a stray response.
        @(negedge clk);
        in_valid = 1'b1; in_alu_out = 32'h0000_0100; in_func3 = 3'b010;
        in_mem_read = 1'b1; in_mem_write = 1'b0; in_pass = {4{32'h1357_9BDF}};
        @(negedge clk);
        in_valid = 1'b0;
        chk("rw_req_valid", req_valid, 1);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        chk("rw_in_wait", req_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw_in_ready", in_ready, 1);
        chk("rw_out_valid", out_valid, 0);
        chk("rw_out_alu_cleared", out_alu_out, 0);
        chk("rw_out_pass_cleared", out_pass, 0);
        rsp_valid = 1'b1; rsp_rdata = 32'hBAD0_BAD0; rsp_err = 1'b0;
        @(negedge clk);
        rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rw_stray_out_valid", out_valid, 0);
            chk("rw_stray_req_valid", req_valid, 0);
            @(negedge clk);
        end
        chk("rw_still_idle", in_ready, 1);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
